// File: rtl/stack_unit.sv
// stack_unit: LIFO operand stack for the stack processor datapath.
// Holds up to DEPTH words and supports three operations:
//   push         - write w_data on top (count + 1)
//   pop          - discard the top entry (count - 1)
//   push and pop - replace the top entry with w_data
// The top two entries are visible combinationally, gated to zero by count.
// A rejected operation (push when full, pop when empty) sets a sticky error
// bit and changes nothing else.
module stack_unit #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [WIDTH-1:0]   w_data,
    output logic [WIDTH-1:0]   top,
    output logic [WIDTH-1:0]   second,
    output logic [PTR_W:0]     count,
    output logic               empty,
    output logic               full,
    output logic               error
);

    localparam logic [PTR_W:0]   ZERO_C  = {(PTR_W+1){1'b0}};
    localparam logic [PTR_W:0]   ONE_C   = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   TWO_C   = {{(PTR_W-1){1'b0}}, 2'b10};
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [WIDTH-1:0] WZERO_C = {WIDTH{1'b0}};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W:0]   count_r;
    logic             error_r;

    logic             empty_s;
    logic             full_s;
    logic [PTR_W:0]   top_cnt_s;
    logic [PTR_W:0]   sec_cnt_s;
    logic [PTR_W-1:0] top_idx_s;
    logic [PTR_W-1:0] sec_idx_s;
    logic             wr_en_s;
    logic [PTR_W-1:0] wr_idx_s;
    logic [PTR_W:0]   count_nxt_s;
    logic             err_set_s;

    // Status flags and read indices of the top two entries, derived from count.
    always_comb begin
        empty_s   = (count_r == ZERO_C);
        full_s    = (count_r == DEPTH_C);
        top_cnt_s = count_r - ONE_C;
        sec_cnt_s = count_r - TWO_C;
        top_idx_s = top_cnt_s[PTR_W-1:0];
        sec_idx_s = sec_cnt_s[PTR_W-1:0];
    end

    // Output read-out; gating uses count so stale popped words never leak out.
    always_comb begin
        if (empty_s) begin
            top = WZERO_C;
        end else begin
            top = mem_r[top_idx_s];
        end
        if (count_r < TWO_C) begin
            second = WZERO_C;
        end else begin
            second = mem_r[sec_idx_s];
        end
        count = count_r;
        empty = empty_s;
        full  = full_s;
        error = error_r;
    end

    // Operation decode: array write, next count and error detection.
    always_comb begin
        wr_en_s     = 1'b0;
        wr_idx_s    = count_r[PTR_W-1:0];
        count_nxt_s = count_r;
        err_set_s   = 1'b0;
        case ({push, pop})
            2'b10: begin
                if (full_s) begin
                    err_set_s = 1'b1;
                end else begin
                    wr_en_s     = 1'b1;
                    wr_idx_s    = count_r[PTR_W-1:0];
                    count_nxt_s = count_r + ONE_C;
                end
            end
            2'b01: begin
                if (empty_s) begin
                    err_set_s = 1'b1;
                end else begin
                    count_nxt_s = count_r - ONE_C;
                end
            end
            2'b11: begin
                // Replace on an empty stack degenerates to a plain push.
                if (empty_s) begin
                    wr_en_s     = 1'b1;
                    wr_idx_s    = {PTR_W{1'b0}};
                    count_nxt_s = ONE_C;
                end else begin
                    wr_en_s  = 1'b1;
                    wr_idx_s = top_idx_s;
                end
            end
            default: begin
                count_nxt_s = count_r;
            end
        endcase
    end

    // Storage array; never cleared, and a write is suppressed while reset wins.
    always_ff @(posedge clk) begin
        if (wr_en_s && !reset) begin
            mem_r[wr_idx_s] <= w_data;
        end
    end

    // Count and sticky error state.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= ZERO_C;
            error_r <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            error_r <= error_r | err_set_s;
        end
    end

endmodule

// File: doc/stack_unit.md
# stack_unit

Hardware operand stack for the stack processor datapath. Holds up to DEPTH 16-bit words with push, pop and replace-top operations, and exposes the top two entries combinationally. It sits directly upstream of reg_file_4: `top` drives the register file's `w_data` on store instructions, and the register file's `r_data` returns to `w_data` here on load instructions. Full/empty status and a sticky error flag are reported to the control unit.

## Interface
- WIDTH, 16, data word width
- DEPTH, 16, number of entries; power of two, at least 2
- PTR_W, 4, log2(DEPTH)
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; priority over all other inputs
- push  in  1  push `w_data` this cycle
- pop  in  1  pop top entry this cycle
- w_data  in  WIDTH  data to push or replace
- top  out  WIDTH  entry at count-1; 0 when empty
- second  out  WIDTH  entry at count-2; 0 when count < 2
- count  out  PTR_W+1  number of valid entries, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- error  out  1  sticky overflow/underflow flag

## Operation
- Storage: DEPTH x WIDTH array plus count register. No separate state machine; state is the count (0..DEPTH) plus the sticky error bit.
- reset=1 at an edge: count←0, error←0. Array contents are not cleared. After reset: top=0, second=0, count=0, empty=1, full=0, error=0.
- push=1, pop=0:
  - If not full: mem[count]←w_data, count←count+1.
  - If full: no change to array or count; error←1 (overflow).
- push=0, pop=1:
  - If not empty: count←count-1; the popped word is not erased.
  - If empty: no change; error←1 (underflow).
- push=1, pop=1 (replace top):
  - If not empty: mem[count-1]←w_data; count unchanged.
  - If empty: behaves as a plain push (count←1), with no error.
  - Never overflows, including when full.
- push=0, pop=0: hold.
- error stays at 1 until reset. A rejected operation changes nothing else.
- Count arithmetic is unsigned PTR_W+1 bits. The array is indexed with the low PTR_W bits. count never exceeds DEPTH and never wraps below 0.
- `top`, `second`, `empty` and `full` are combinational from count and the array. Gating to 0 uses count, not stale array data.

## Timing
- Single-cycle: an operation sampled at edge N is reflected in every output immediately after edge N.
- No handshake. push/pop are one-cycle strobes, and holding them high repeats the operation every cycle.
- A popped value must be read from `top` in the same cycle pop is asserted, before the edge.
- reset asserted mid-sequence wins over simultaneous push/pop. The next cycle shows the empty state.
- Outputs are glitch-tolerant only. Consumers sample on clk.

## Test plan
- Reset, then push 10, 20, 30, 40 on consecutive cycles → count=4, top=40, second=30, error=0. Four pops then return top values 40, 30, 20, 10, and after the last pop empty=1, top=0.
- Reset then a single pop → count=0, empty=1, error=1. A following push of 5 gives top=5, count=1, error still 1. A reset clears error to 0.
- Push 16 words 1..16 → full=1, top=16. A 17th push of 99 sets error=1 and leaves count=16, top=16.
- Push 7, push 8, then push=pop=1 with w_data=42 → count=2, top=42, second=7. Replace when empty with w_data=3 → count=1, top=3, error=0.
- Push 1, 2, 3, then assert reset together with push of 9 → count=0, top=0, empty=1. Then push 4 → top=4, second=0.
- Full stack with push=pop=1, w_data=77 → count=16, top=77, full=1, error=0.
